// File: rtl/mediana_pkg.sv
// Types and sizes shared by the 9-element median engine and its feeder.
package mediana_pkg;

  localparam int LARGURA = 8;
  localparam int N_ELEM  = 9;
  localparam int CNT_W   = $clog2(N_ELEM);

  typedef logic [LARGURA-1:0] elem_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {
    COLETA,
    INICIA,
    ESPERA,
    ENTREGA
  } estado_t;

endpackage

// File: rtl/alimentador_mediana.sv
// Feeder for the median engine: serial window in, one-cycle iniciar, result out; iniciar one cycle after 9th sample, result one cycle after flag.
// No input accepted while a job is in flight; result held until res_pronto. MEDIANA_CICLOS_EN adds res_ciclos.
module alimentador_mediana
  import mediana_pkg::*;
#(
  parameter int MAX_ESPERA = 0,
  parameter int CICLOS_W   = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  elem_t in_dado,
  input  logic  in_valido,
  output logic  in_pronto,
  output elem_t janela [N_ELEM],
  output logic  iniciar,
  input  logic  flag,
  input  elem_t saida,
  output elem_t res_dado,
  output logic  res_erro,
  output logic  res_valido,
  input  logic  res_pronto
`ifdef MEDIANA_CICLOS_EN
  ,
  output logic [CICLOS_W-1:0] res_ciclos
`endif
);

  localparam int               ESP_W   = (MAX_ESPERA > 1) ? $clog2(MAX_ESPERA) : 1;
  localparam logic [ESP_W-1:0] ESP_ULT = ESP_W'(MAX_ESPERA - 1);

  if (N_ELEM != 9) begin : g_chk_n_elem
    $error("alimentador_mediana: N_ELEM must be 9");
  end
  if (CICLOS_W < 1) begin : g_chk_ciclos_w
    $error("alimentador_mediana: CICLOS_W must be at least 1");
  end

  estado_t          r_estado;
  estado_t          w_prox;
  cnt_t             r_cnt;
  elem_t            r_janela [N_ELEM];
  elem_t            r_res_dado;
  logic             r_res_erro;
  logic [ESP_W-1:0] r_espera;
  logic             w_aceita;
  logic             w_ultimo;
  logic             w_esgotou;
  logic             w_captura;

  assign w_ultimo  = (r_cnt == cnt_t'(N_ELEM - 1));
  assign w_esgotou = (MAX_ESPERA != 0) && (r_espera == ESP_ULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= COLETA;
    end else begin
      r_estado <= w_prox;
    end
  end

  // flag is only looked at in ESPERA, so a flag left high by the previous job is harmless.
  always_comb begin
    w_prox     = r_estado;
    in_pronto  = 1'b0;
    iniciar    = 1'b0;
    res_valido = 1'b0;
    w_aceita   = 1'b0;
    w_captura  = 1'b0;
    case (r_estado)
      COLETA: begin
        in_pronto = !reset;
        w_aceita  = in_valido && !reset;
        if (w_aceita && w_ultimo) begin
          w_prox = INICIA;
        end
      end
      INICIA: begin
        iniciar = 1'b1;
        w_prox  = ESPERA;
      end
      ESPERA: begin
        if (flag || w_esgotou) begin
          w_captura = 1'b1;
          w_prox    = ENTREGA;
        end
      end
      ENTREGA: begin
        res_valido = 1'b1;
        if (res_pronto) begin
          w_prox = COLETA;
        end
      end
      default: w_prox = COLETA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      for (int i = 0; i < N_ELEM; i++) begin
        r_janela[i] <= '0;
      end
      r_res_dado <= '0;
      r_res_erro <= 1'b0;
    end else begin
      if (w_aceita) begin
        r_janela[r_cnt] <= in_dado;
        r_cnt           <= w_ultimo ? '0 : r_cnt + 1'b1;
      end
      if (w_captura) begin
        r_res_dado <= flag ? saida : '0;
        r_res_erro <= !flag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_espera <= '0;
    end else if (r_estado == ESPERA) begin
      r_espera <= r_espera + 1'b1;
    end else begin
      r_espera <= '0;
    end
  end

`ifdef MEDIANA_CICLOS_EN
  logic [CICLOS_W-1:0] r_ciclos;
  logic [CICLOS_W-1:0] r_res_ciclos;
  logic [CICLOS_W-1:0] w_ciclos_inc;

  // Value including the current ESPERA cycle, saturating instead of wrapping.
  assign w_ciclos_inc = (&r_ciclos) ? r_ciclos : r_ciclos + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ciclos     <= '0;
      r_res_ciclos <= '0;
    end else begin
      r_ciclos <= (r_estado == ESPERA) ? w_ciclos_inc : '0;
      if (w_captura) begin
        r_res_ciclos <= w_ciclos_inc;
      end
    end
  end

  assign res_ciclos = r_res_ciclos;
`endif

  assign janela   = r_janela;
  assign res_dado = r_res_dado;
  assign res_erro = r_res_erro;

endmodule
